// File: rtl/mem_pkg.sv
// Shared types and constants for the memory line arbiter and its line buffers.
package mem_pkg;

    localparam int BURST_LEN_DEF = 4;
    localparam int WORD_W        = 32;
    localparam int LINE_OFF_BITS = $clog2(BURST_LEN_DEF) + 2;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } client_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [BURST_LEN_DEF-1:0][WORD_W-1:0] line_t;

    // Clears the word and byte offset of a line holding burst_len words.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int burst_len);
        return addr & ~(32'(burst_len * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One assembled cache line plus the beat index used to fill it or drain a writeback.
module line_beat_buffer
    import mem_pkg::*;
#(
    parameter  int BURST_LEN = BURST_LEN_DEF,
    localparam int IDX_W     = $clog2(BURST_LEN)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cnt_clr,
    input  logic                              beat_en,
    input  logic                              store_en,
    input  logic [WORD_W-1:0]                 beat_data,
    output logic [BURST_LEN-1:0][WORD_W-1:0]  line,
    output logic [IDX_W-1:0]                  cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the line storage is reset as well, so a fill cut short by reset leaves no stale words.
            line <= '0;
            cnt  <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (beat_en) begin
            // A power-of-two length lets the index wrap to 0 on its own after the last beat.
            cnt <= cnt + 1'b1;
            if (store_en) begin
                line[cnt] <= beat_data;
            end
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Round-robin burst arbiter between the L1 I/D caches and single-port main memory.
// Defining MEM_ARB_TIMEOUT_EN adds a beat watchdog and the err output.
module mem_line_arbiter
    import mem_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [31:0]              i_addr,
    output logic [BURST_LEN*32-1:0]  i_rdata,
    output logic                     i_done,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [31:0]              d_addr,
    input  logic [BURST_LEN*32-1:0]  d_wdata,
    output logic [BURST_LEN*32-1:0]  d_rdata,
    output logic                     d_done,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_din,
    input  logic [31:0]              mem_dout,
    input  logic                     mem_valid,
    output logic                     busy
`ifdef MEM_ARB_TIMEOUT_EN
    , output logic                   err
`endif
);

    localparam int IDX_W = $clog2(BURST_LEN);

    state_e                        state, state_nx;
    client_e                       grant, last_grant, pick;
    logic                          is_write;
    logic [31:0]                   line_addr;
    logic [BURST_LEN-1:0][31:0]    wline, i_line, d_line;
    logic [IDX_W-1:0]              i_cnt, d_cnt, cnt;
    logic                          in_xfer, beat, last_beat, abort;

    assign in_xfer   = (state == ST_XFER);
    assign beat      = in_xfer && mem_valid;
    assign cnt       = (grant == CLI_I) ? i_cnt : d_cnt;
    assign last_beat = beat && (cnt == IDX_W'(BURST_LEN - 1));
    // D wins a tie unless it was the previous winner.
    assign pick      = (d_req && (!i_req || last_grant == CLI_I)) ? CLI_D : CLI_I;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog;
    logic            aborted;

    assign abort = in_xfer && !mem_valid && (wdog == WD_W'(TIMEOUT - 1));
    assign err   = (state == ST_DONE) && aborted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog    <= '0;
            aborted <= 1'b0;
        end else begin
            aborted <= abort;
            wdog    <= (!in_xfer || mem_valid) ? '0 : wdog + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= CLI_I;
            last_grant <= CLI_I;
            is_write   <= 1'b0;
            line_addr  <= '0;
            wline      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
            if (state == ST_IDLE && (i_req || d_req)) begin
                grant      <= pick;
                last_grant <= pick;
                is_write   <= (pick == CLI_D) && d_we;
                line_addr  <= line_base((pick == CLI_D) ? d_addr : i_addr, BURST_LEN);
                wline      <= d_wdata;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nx = state;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        busy     = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (i_req || d_req) state_nx = ST_XFER;
            end
            ST_XFER: begin
                mem_re   = !is_write;
                mem_we   = is_write;
                mem_addr = line_addr;
                mem_din  = is_write ? wline[cnt] : '0;
                if (last_beat || abort) state_nx = ST_DONE;
            end
            ST_DONE: begin
                i_done   = (grant == CLI_I);
                d_done   = (grant == CLI_D);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    line_beat_buffer #(.BURST_LEN(BURST_LEN)) u_i_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_clr   (state == ST_IDLE),
        .beat_en   (beat && grant == CLI_I),
        .store_en  (1'b1),
        .beat_data (mem_dout),
        .line      (i_line),
        .cnt       (i_cnt)
    );

    // The D buffer's index also paces writebacks; its line is only written by fills.
    line_beat_buffer #(.BURST_LEN(BURST_LEN)) u_d_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_clr   (state == ST_IDLE),
        .beat_en   (beat && grant == CLI_D),
        .store_en  (!is_write),
        .beat_data (mem_dout),
        .line      (d_line),
        .cnt       (d_cnt)
    );

    assign i_rdata = i_line;
    assign d_rdata = d_line;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed scenarios plus randomized traffic
// against a request-level model (round-robin choice, line address, expected lines).
module tb_mem_line_arbiter;
    import mem_pkg::*;

    localparam int BL     = BURST_LEN_DEF;
    localparam int TO_CYC = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    line_t       i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    line_t       d_wdata = '0;
    line_t       d_rdata;
    logic        d_done;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = '0;
    logic        mem_valid = 1'b0;
    logic        busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        err;
`endif

    int      checks = 0;
    int      failures = 0;
    client_e last_grant_m = CLI_I;
    line_t   exp_i_line = '0;
    line_t   exp_d_line = '0;

    mem_line_arbiter #(.BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_valid (mem_valid),
        .busy      (busy)
`ifdef MEM_ARB_TIMEOUT_EN
        , .err     (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_line_addr(input logic [31:0] a);
        return a & ~((32'd1 << LINE_OFF_BITS) - 32'd1);
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < BL; k++) l[k] = $urandom;
        return l;
    endfunction

    // Memory-side responder: waits (bounded) for RE/WE, then serves n_beats beats with gaps.
    // Entered and left at a negedge; after a full burst it returns in the DONE cycle.
    task automatic do_burst(input int n_beats, input int first_gap, input int gap_min,
                            input int gap_max, input line_t rd,
                            output logic [31:0] addr, output int lat,
                            output logic re_and, output logic re_or,
                            output logic we_and, output logic we_or,
                            output logic addr_stable, output line_t din, output bit to);
        to = 1'b0; lat = 0; din = '0; addr = '0; addr_stable = 1'b1;
        re_and = 1'b1; re_or = 1'b0; we_and = 1'b1; we_or = 1'b0;
        mem_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(mem_re || mem_we) && lat < 20);
        if (!(mem_re || mem_we)) begin
            to = 1'b1;
            return;
        end
        addr = mem_addr;
        for (int k = 0; k < n_beats; k++) begin
            int gap;
            gap = (k == 0) ? first_gap : int'($urandom_range(gap_max, gap_min));
            for (int g = 0; g <= gap; g++) begin
                if (g > 0) @(negedge clk);
                re_and &= mem_re; re_or |= mem_re;
                we_and &= mem_we; we_or |= mem_we;
                addr_stable &= (mem_addr == addr);
            end
            mem_valid = 1'b1;
            mem_dout  = rd[k];
            #1;
            din[k] = mem_din;
            @(negedge clk);
            mem_valid = 1'b0;
            mem_dout  = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_re, mem_we, busy, i_done, d_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {mem_re, mem_we, busy, i_done, d_done});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem got addr=%h din=%h exp=0", mem_addr, mem_din);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got i=%h d=%h exp=0", i_rdata, d_rdata);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err);
        end
`endif
        rst_n = 1'b1;
        last_grant_m = CLI_I; exp_i_line = '0; exp_d_line = '0;
        @(negedge clk);
    endtask

    task automatic test_fill_basic();
        logic [31:0] addr; int lat; logic ra, ro, wa, wo, st; line_t din, rd; bit to;
        rd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        i_addr = 32'h0000_1234; i_req = 1'b1;
        do_burst(BL, 10, 0, 0, rd, addr, lat, ra, ro, wa, wo, st, din, to);
        checks++;
        if (to || addr !== 32'h0000_1230 || lat != 1) begin
            failures++;
            $display("FAIL fill_addr got to=%0d addr=%h lat=%0d exp addr=00001230 lat=1", to, addr, lat);
        end
        checks++;
        if (!(ra && !wo && st)) begin
            failures++;
            $display("FAIL fill_dir got re_all=%b we_any=%b addr_stable=%b exp 1,0,1", ra, wo, st);
        end
        checks++;
        if ({i_done, d_done, mem_re, busy} !== 4'b1001 || i_rdata !== rd) begin
            failures++;
            $display("FAIL fill_done got flags=%b line=%h exp flags=1001 line=%h",
                     {i_done, d_done, mem_re, busy}, i_rdata, rd);
        end
        exp_i_line = rd; last_grant_m = CLI_I;
        @(negedge clk);
        i_req = 1'b0;
        checks++;
        if ({i_done, d_done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL fill_pulse got=%b exp=000", {i_done, d_done, busy});
        end
    endtask

    task automatic test_writeback();
        logic [31:0] addr; int lat; logic ra, ro, wa, wo, st; line_t din, wl; bit to;
        wl = {32'd4, 32'd3, 32'd2, 32'd1};
        d_we = 1'b1; d_addr = 32'h40; d_wdata = wl; d_req = 1'b1;
        do_burst(BL, 0, 1, 2, '0, addr, lat, ra, ro, wa, wo, st, din, to);
        checks++;
        if (to || addr !== 32'h40 || !(wa && !ro)) begin
            failures++;
            $display("FAIL wb_dir got to=%0d addr=%h we_all=%b re_any=%b exp addr=40 1,0", to, addr, wa, ro);
        end
        checks++;
        if (din !== wl) begin
            failures++;
            $display("FAIL wb_din got=%h exp=%h", din, wl);
        end
        checks++;
        if ({i_done, d_done} !== 2'b01 || d_rdata !== exp_d_line || i_rdata !== exp_i_line) begin
            failures++;
            $display("FAIL wb_done got done=%b d_rdata=%h exp done=01 d_rdata=%h", {i_done, d_done}, d_rdata, exp_d_line);
        end
        last_grant_m = CLI_D;
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        checks++;
        if ({d_done, busy, mem_din} !== 34'b0) begin
            failures++;
            $display("FAIL wb_pulse got done=%b busy=%b din=%h exp 0", d_done, busy, mem_din);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] addr; int lat; logic ra, ro, wa, wo, st; line_t din, rd; bit to;
        client_e exp_c;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_grant_m = CLI_I; exp_i_line = '0; exp_d_line = '0;
        i_addr = 32'h3008; d_addr = 32'h2004; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int n = 0; n < 3; n++) begin
            exp_c = (n % 2 == 0) ? CLI_D : CLI_I;
            rd = rand_line();
            do_burst(BL, 0, 0, 1, rd, addr, lat, ra, ro, wa, wo, st, din, to);
            checks++;
            if (to || addr !== ((exp_c == CLI_D) ? 32'h2000 : 32'h3000)) begin
                failures++;
                $display("FAIL arb_order n=%0d got addr=%h exp client=%s", n, addr, exp_c.name());
            end
            checks++;
            if ({i_done, d_done} !== ((exp_c == CLI_D) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL arb_done n=%0d got=%b exp client=%s", n, {i_done, d_done}, exp_c.name());
            end
            if (exp_c == CLI_D) exp_d_line = rd; else exp_i_line = rd;
            checks++;
            if (i_rdata !== exp_i_line || d_rdata !== exp_d_line) begin
                failures++;
                $display("FAIL arb_data n=%0d got i=%h d=%h exp i=%h d=%h", n, i_rdata, d_rdata, exp_i_line, exp_d_line);
            end
            last_grant_m = exp_c;
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_stray_valid();
        logic [31:0] addr; int lat; logic ra, ro, wa, wo, st; line_t din, rd; bit to;
        @(negedge clk);
        mem_valid = 1'b1; mem_dout = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_valid = 1'b0; mem_dout = '0;
        checks++;
        if (i_rdata !== exp_i_line || d_rdata !== exp_d_line || busy !== 1'b0) begin
            failures++;
            $display("FAIL stray_idle got i=%h d=%h busy=%b exp unchanged, busy=0", i_rdata, d_rdata, busy);
        end
        rd = rand_line();
        i_addr = 32'h0000_5A5C; i_req = 1'b1;
        do_burst(BL, 3, 3, 3, rd, addr, lat, ra, ro, wa, wo, st, din, to);
        checks++;
        if (to || addr !== 32'h0000_5A50 || i_rdata !== rd || i_done !== 1'b1) begin
            failures++;
            $display("FAIL gap_fill got addr=%h line=%h done=%b exp addr=00005a50 line=%h done=1", addr, i_rdata, i_done, rd);
        end
        exp_i_line = rd; last_grant_m = CLI_I;
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] addr; int lat; logic ra, ro, wa, wo, st; line_t din, rd; bit to;
        rd = rand_line();
        i_addr = 32'h0000_0100; i_req = 1'b1;
        do_burst(2, 0, 0, 1, rd, addr, lat, ra, ro, wa, wo, st, din, to);
        checks++;
        if (to || busy !== 1'b1 || mem_re !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got to=%0d busy=%b re=%b exp 0,1,1", to, busy, mem_re);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_re, mem_we, busy, i_done, d_done} !== 5'b0 || mem_addr !== 32'h0 ||
            i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL midrst_clear got ctrl=%b addr=%h i=%h d=%h exp all 0",
                     {mem_re, mem_we, busy, i_done, d_done}, mem_addr, i_rdata, d_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_grant_m = CLI_I; exp_i_line = '0; exp_d_line = '0;
        rd = rand_line();
        i_addr = 32'h0000_0208; i_req = 1'b1;
        do_burst(BL, 0, 0, 1, rd, addr, lat, ra, ro, wa, wo, st, din, to);
        checks++;
        if (to || addr !== 32'h0000_0200 || i_rdata !== rd || i_done !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after got addr=%h line=%h done=%b exp addr=00000200 line=%h done=1", addr, i_rdata, i_done, rd);
        end
        exp_i_line = rd; last_grant_m = CLI_I;
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] addr, exp_addr, ia, da; int lat; logic ra, ro, wa, wo, st; line_t din, rd, dw;
        bit to, ip, dp, dwe, exp_wr;
        client_e exp_c;
        ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dwe = 1'b0; dw = '0;
        for (int n = 0; n < 40 && (n < 24 || ip || dp); n++) begin
            if (n < 24 && !ip && $urandom_range(1, 0) == 1) begin
                ip = 1'b1; ia = $urandom;
            end
            if (n < 24 && !dp && (!ip || $urandom_range(1, 0) == 1)) begin
                dp = 1'b1; da = $urandom; dwe = 1'($urandom_range(1, 0)); dw = rand_line();
            end
            i_req = ip; i_addr = ia;
            d_req = dp; d_addr = da; d_we = dwe; d_wdata = dw;
            if (ip && dp) exp_c = (last_grant_m == CLI_I) ? CLI_D : CLI_I;
            else          exp_c = dp ? CLI_D : CLI_I;
            exp_wr   = (exp_c == CLI_D) && dwe;
            exp_addr = exp_line_addr((exp_c == CLI_D) ? da : ia);
            rd = rand_line();
            do_burst(BL, int'($urandom_range(2, 0)), 0, 2, rd, addr, lat, ra, ro, wa, wo, st, din, to);
            checks++;
            if (to || addr !== exp_addr || !st) begin
                failures++;
                $display("FAIL rnd_addr n=%0d got to=%0d addr=%h exp addr=%h", n, to, addr, exp_addr);
                break;
            end
            checks++;
            if (exp_wr ? !(wa && !ro) : !(ra && !wo)) begin
                failures++;
                $display("FAIL rnd_dir n=%0d got re=%b/%b we=%b/%b exp write=%0d", n, ra, ro, wa, wo, exp_wr);
            end
            if (exp_wr) begin
                checks++;
                if (din !== dw) begin
                    failures++;
                    $display("FAIL rnd_din n=%0d got=%h exp=%h", n, din, dw);
                end
            end else if (exp_c == CLI_D) begin
                exp_d_line = rd;
            end else begin
                exp_i_line = rd;
            end
            checks++;
            if ({i_done, d_done} !== ((exp_c == CLI_I) ? 2'b10 : 2'b01) ||
                i_rdata !== exp_i_line || d_rdata !== exp_d_line) begin
                failures++;
                $display("FAIL rnd_done n=%0d got done=%b i=%h d=%h exp client=%s i=%h d=%h",
                         n, {i_done, d_done}, i_rdata, d_rdata, exp_c.name(), exp_i_line, exp_d_line);
            end
            last_grant_m = exp_c;
            @(negedge clk);
            if (exp_c == CLI_I) ip = 1'b0; else dp = 1'b0;
            i_req = ip; d_req = dp;
            checks++;
            if ({i_done, d_done, busy} !== 3'b000) begin
                failures++;
                $display("FAIL rnd_pulse n=%0d got=%b exp=000", n, {i_done, d_done, busy});
            end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_grant_m = CLI_I; exp_i_line = '0; exp_d_line = '0;
        i_addr = 32'h0000_0400; i_req = 1'b1;
        @(negedge clk);
        repeat (TO_CYC - 1) @(negedge clk);
        checks++;
        if ({mem_re, err, i_done} !== 3'b100) begin
            failures++;
            $display("FAIL to_before got re/err/done=%b exp=100", {mem_re, err, i_done});
        end
        @(negedge clk);
        checks++;
        if ({mem_re, err, i_done, d_done} !== 4'b0110 || i_rdata !== exp_i_line) begin
            failures++;
            $display("FAIL to_abort got re/err/idone/ddone=%b line=%h exp=0110 line=%h",
                     {mem_re, err, i_done, d_done}, i_rdata, exp_i_line);
        end
        @(negedge clk);
        i_req = 1'b0;
        checks++;
        if ({err, i_done} !== 2'b00) begin
            failures++;
            $display("FAIL to_pulse got err/done=%b exp=00", {err, i_done});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_basic();
        test_writeback();
        test_arbitration();
        test_stray_valid();
        test_reset_mid_burst();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
